// File: rtl/fifo_16i_8o_prefetch_pkg.sv
// Shared constants for the 16-bit-in / 8-bit-out prefetch FIFO.
// Byte order is controlled by FIFO_16I_8O_BYTE_SWAP_EN.
// Undefined: low byte first. Defined: high byte first.
package fifo_16i_8o_prefetch_pkg;

    localparam int unsigned WR_W = 16;
    localparam int unsigned RD_W = 8;

`ifdef FIFO_16I_8O_BYTE_SWAP_EN
    localparam logic HI_BYTE_FIRST = 1'b1;
`else
    localparam logic HI_BYTE_FIRST = 1'b0;
`endif

    // Byte of a stored word shown for a given selector value.
    // Selector 0 is the first byte emitted and 1 is the second.
    function automatic logic [RD_W-1:0] pick_byte(input logic [WR_W-1:0] word,
                                                  input logic             second);
        logic hi;
        hi = second ^ HI_BYTE_FIRST;
        return hi ? word[WR_W-1:RD_W] : word[RD_W-1:0];
    endfunction

endpackage

// File: rtl/fifo_16i_8o_ram.sv
// Simple dual-port word storage for fifo_16i_8o_prefetch.
// It has one write port and one read port.
// A read returns its data one cycle after the address is presented.
// If a read and a write hit the same address in the same cycle, the read returns the old data.
module fifo_16i_8o_ram
    import fifo_16i_8o_prefetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WR_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WR_W-1:0]   rd_data
);

    logic [WR_W-1:0] mem [0:(1 << ADDR_W)-1];
    logic [WR_W-1:0] rd_data_q;

    // Registered write and registered read of the storage array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_16i_8o_prefetch.sv
// FIFO that accepts 16-bit words and emits them as two bytes, first-word-fall-through.
// Byte order: see FIFO_16I_8O_BYTE_SWAP_EN in fifo_16i_8o_prefetch_pkg.
//
// Read side has two stages:
//   - Prefetch stage: the RAM output register, plus a bypass register for a word
//     written in the same cycle its address is read.
//   - Current-word register with a byte selector.
// The prefetch word still occupies its RAM slot.
// rd_ptr advances only when that word moves into the current-word register.
// So wr_ptr - rd_ptr counts the RAM and prefetch words.
module fifo_16i_8o_prefetch
    import fifo_16i_8o_prefetch_pkg::*;
#(
    parameter int DEPTH_WIDTH = 9,
    parameter int AFULL_WORDS = 2**DEPTH_WIDTH - 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    output logic            wr_vld,
    input  logic [WR_W-1:0] wr_data,
    output logic            wr_afull,
    input  logic            rd_en,
    output logic            rd_vld,
    output logic [RD_W-1:0] rd_data
);

    localparam logic [DEPTH_WIDTH:0] PTR_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};

    logic [DEPTH_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                 wr_vld_q, wr_vld_d;
    logic                 pf_vld_q, pf_vld_d;
    logic                 byp_q, byp_d;
    logic [WR_W-1:0]      byp_data_q, byp_data_d;
    logic                 cur_vld_q, cur_vld_d;
    logic [WR_W-1:0]      cur_data_q, cur_data_d;
    logic                 sel_q, sel_d;

    logic                 do_wr;
    logic                 do_pop;
    logic                 load_cur;
    logic                 full_d;
    logic                 ram_we;
    logic [WR_W-1:0]      ram_rdata;
    logic [WR_W-1:0]      pf_data;
    logic [DEPTH_WIDTH:0] count;

    fifo_16i_8o_ram #(
        .ADDR_W (DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[DEPTH_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_d[DEPTH_WIDTH-1:0]),
        .rd_data (ram_rdata)
    );

    assign ram_we  = do_wr && !rst;
    assign pf_data = byp_q ? byp_data_q : ram_rdata;
    assign count   = wr_ptr_q - rd_ptr_q;

    // Next-state logic for the pointers, the prefetch stage and the current-word/byte selector.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cur_vld_d  = cur_vld_q;
        cur_data_d = cur_data_q;
        sel_d      = sel_q;

        do_wr    = wr_en && wr_vld_q;
        do_pop   = rd_en && cur_vld_q;
        load_cur = pf_vld_q && (!cur_vld_q || (do_pop && sel_q));

        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (load_cur) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (load_cur) begin
            cur_data_d = pf_data;
            cur_vld_d  = 1'b1;
            sel_d      = 1'b0;
        end else if (do_pop && sel_q) begin
            cur_vld_d = 1'b0;
            sel_d     = 1'b0;
        end else if (do_pop) begin
            sel_d = 1'b1;
        end

        // The RAM is always read at rd_ptr_d, so the prefetch stage is valid whenever that slot holds data.
        // A write landing on that same slot this cycle is not yet visible in the RAM read, so it goes through the bypass.
        pf_vld_d   = (rd_ptr_d != wr_ptr_d);
        byp_d      = do_wr && (wr_ptr_q == rd_ptr_d);
        byp_data_d = wr_data;

        full_d   = (wr_ptr_d[DEPTH_WIDTH] != rd_ptr_d[DEPTH_WIDTH]) &&
                   (wr_ptr_d[DEPTH_WIDTH-1:0] == rd_ptr_d[DEPTH_WIDTH-1:0]);
        wr_vld_d = !full_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_vld_q   <= 1'b1;
            pf_vld_q   <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            cur_vld_q  <= 1'b0;
            cur_data_q <= '0;
            sel_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_vld_q   <= wr_vld_d;
            pf_vld_q   <= pf_vld_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
            cur_vld_q  <= cur_vld_d;
            cur_data_q <= cur_data_d;
            sel_q      <= sel_d;
        end
    end

    // Outputs are forced idle for as long as rst is held high.
    always_comb begin
        wr_vld   = wr_vld_q && !rst;
        wr_afull = !rst && (int'(count) >= AFULL_WORDS);
        rd_vld   = cur_vld_q && !rst;
        rd_data  = rst ? '0 : pick_byte(cur_data_q, sel_q);
    end

endmodule
